sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-master arbiter and sequencer in front of the base SRAM controller (`sram_ctrl`). Master 0 is the CPU device-bus path and master 1 is a DMA/framebuffer reader. The block accepts one transaction per master through a req/ack handshake and picks the winner round-robin. It drives the single `sram_ctrl` request port and returns read data and a one-cycle completion pulse to the winner, so the SRAM datapath needs no changes.

## Interface
- `READ_LAT`, 1: cycles `mem_enable_o` is held for a read before `mem_data_load_i` is sampled (legal 1..15)
- `clk` in 1: system clock (25 MHz domain)
- `rst_n` in 1: asynchronous, active-low reset
- `m0_req_i` / `m1_req_i` in 1: transaction request; held high with fields stable until the matching ack
- `m0_write_i` / `m1_write_i` in 1: 1 = write, 0 = read
- `m0_addr_i` / `m1_addr_i` in 32: physical address
- `m0_byte_select_i` / `m1_byte_select_i` in 4: byte enables
- `m0_data_save_i` / `m1_data_save_i` in 32: write data
- `m0_data_load_o` / `m1_data_load_o` out 32: read data, valid in the ack cycle
- `m0_ack_o` / `m1_ack_o` out 1: one-cycle completion pulse
- `mem_enable_o` out 1: to `sram_ctrl` `enable_i`
- `mem_read_enable_o` out 1: to `sram_ctrl` `readEnable_i`
- `mem_addr_o` out 32, `mem_byte_select_o` out 4, `mem_data_save_o` out 32: to `sram_ctrl`
- `mem_data_load_i` in 32, `mem_busy_i` in 1: from `sram_ctrl`
- `owner_o` out 2: 2'b00 idle, 2'b01 m0, 2'b10 m1 (debug/LED)

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE**
  - If any req is high: arbitrate, latch the winner's write/addr/byte_select/data into the `mem_*` registers, record the winner in `owner`, go to ACCESS.
  - If no req is high: stay in IDLE.
- **Arbitration**
  - Single requester: it wins.
  - Both requesting: the master not granted last wins.
  - `last_grant` resets to m1, so m0 wins the first tie.
  - `last_grant` updates at every grant.
- **ACCESS, read**
  - `mem_enable_o`=1, `mem_read_enable_o`=1 for exactly READ_LAT cycles.
  - On the last of those cycles, `mem_data_load_i` is captured into the winner's data_load register; then go to ACK.
- **ACCESS, write**
  - `mem_enable_o`=1, `mem_read_enable_o`=0.
  - `mem_busy_i` is ignored in the first ACCESS cycle.
  - Leave for ACK on the first later cycle with `mem_busy_i`=0, so a write lasts at least 2 cycles.
- **ACK**
  - `mem_enable_o`=0; the winner's ack is 1 for this cycle only; the loser's ack stays 0.
  - Next state is IDLE.
- **Requester rule:** deassert or replace req on the clock edge ending the ack cycle. A req still high in the following IDLE cycle is treated as a new transaction.
- A non-granted requester's inputs are ignored; its req stays pending with no timeout.
- `mX_data_load_o` holds its value until the next read for that master completes. Writes do not modify it.

## Timing
- Reset values (async on `rst_n` low):
  - state IDLE, `last_grant`=m1, `owner_o`=0
  - all `mem_*` outputs 0
  - both acks 0, both data_load 0
- All outputs are registered.
- Read: req sampled high in IDLE at cycle N gives `mem_enable_o` at N+1..N+READ_LAT and ack at N+READ_LAT+1.
- Write: `mem_enable_o` from N+1 until the first cycle ≥N+2 with busy low; ack one cycle later.
- Back-to-back throughput: one IDLE cycle between transactions, so a read costs READ_LAT+2 cycles.
- Reset asserted mid-transaction:
  - The transaction is dropped with no ack.
  - `mem_enable_o` drops immediately, and a partial SRAM write is accepted.
  - The requester re-issues after reset.
- Req rising during ACCESS/ACK is not sampled until IDLE.

## Structure
- Package `sram_arb_pkg`:
  - state enum (IDLE/ACCESS/ACK, 2-bit)
  - owner encodings (`OWN_NONE`, `OWN_M0`, `OWN_M1`)
  - read-latency counter width constant (4)
- Sub-module `rr_arb2`: combinational 2-way round-robin pick from `req[1:0]` and `last_grant`, producing a one-hot grant. Instantiated once.
- Top level: FSM, latency counter, latched request registers, per-master data_load/ack registers.

## Test plan
- Reset, then m0 read 0x0000_0010 with memory returning 0x1234_5678, READ_LAT=1 → `mem_enable_o` high 1 cycle with `mem_read_enable_o`=1, `m0_ack_o` at N+2, `m0_data_load_o`=0x1234_5678, m1 outputs unchanged.
- m1 write addr 0x20, data 0xDEAD_BEEF, be 0xF, `mem_busy_i` high 3 cycles → `mem_data_save_o`=0xDEAD_BEEF, `mem_read_enable_o`=0, `m1_ack_o` one cycle after busy falls.
- Both req high continuously, 4 reads each → grants alternate m0, m1, m0, m1; each ack a single pulse; `owner_o` tracks 01/10.
- m1 holds req while m0 issues 10 back-to-back requests → m1 granted no later than the second arbitration (no starvation).
- READ_LAT=3, `rst_n` pulled low in the 2nd ACCESS cycle → `mem_enable_o` 0 at once, no ack, `owner_o`=0; after release, a re-issued read completes normally.
- After an ack, req kept high one extra cycle → a second full transaction runs (documents the handshake rule).

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StAck    = 2'd2
    } arb_state_e;

    // Owner encodings double as the one-hot grant vector {m1, m0}.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int unsigned LatCntWidth = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of the single sram_ctrl request port.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic        m0_write_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_byte_select_i,
    input  logic [31:0] m0_data_save_i,
    output logic [31:0] m0_data_load_o,
    output logic        m0_ack_o,
    input  logic        m1_req_i,
    input  logic        m1_write_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_byte_select_i,
    input  logic [31:0] m1_data_save_i,
    output logic [31:0] m1_data_load_o,
    output logic        m1_ack_o,
    output logic        mem_enable_o,
    output logic        mem_read_enable_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_byte_select_o,
    output logic [31:0] mem_data_save_o,
    input  logic [31:0] mem_data_load_i,
    input  logic        mem_busy_i,
    output logic [1:0]  owner_o
);

    localparam logic [LatCntWidth-1:0] LatFirst = LatCntWidth'(1);
    localparam logic [LatCntWidth-1:0] LatLast  = LatCntWidth'(READ_LAT);
    localparam logic [LatCntWidth-1:0] LatMax   = '1;

    arb_state_e state_q, state_d;

    logic [1:0]             req;
    logic [1:0]             gnt;
    logic                   sel;
    logic                   access_done;
    logic                   last_grant_q, last_grant_d;
    logic [1:0]             owner_q, owner_d;
    logic                   write_q, write_d;
    logic [LatCntWidth-1:0] lat_cnt_q, lat_cnt_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_ren_q, mem_ren_d;
    logic [31:0]            addr_q, addr_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            load0_q, load0_d;
    logic [31:0]            load1_q, load1_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;

    assign req = {m1_req_i, m0_req_i};
    assign sel = gnt[1];

    rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    // A write ignores busy in its first ACCESS cycle, so it always lasts at least two.
    assign access_done = write_q ? ((lat_cnt_q != LatFirst) && !mem_busy_i)
                                 : (lat_cnt_q == LatLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|req) state_d = StAccess;
            StAccess: if (access_done) state_d = StAck;
            StAck:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        lat_cnt_d    = lat_cnt_q;
        mem_en_d     = mem_en_q;
        mem_ren_d    = mem_ren_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        load0_d      = load0_q;
        load1_d      = load1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    last_grant_d = sel;
                    owner_d      = gnt;
                    write_d      = sel ? m1_write_i : m0_write_i;
                    addr_d       = sel ? m1_addr_i : m0_addr_i;
                    be_d         = sel ? m1_byte_select_i : m0_byte_select_i;
                    wdata_d      = sel ? m1_data_save_i : m0_data_save_i;
                    mem_en_d     = 1'b1;
                    mem_ren_d    = sel ? !m1_write_i : !m0_write_i;
                    lat_cnt_d    = LatFirst;
                end
            end
            StAccess: begin
                if (lat_cnt_q != LatMax) lat_cnt_d = lat_cnt_q + LatFirst;
                if (access_done) begin
                    mem_en_d  = 1'b0;
                    mem_ren_d = 1'b0;
                    ack0_d    = owner_q[0];
                    ack1_d    = owner_q[1];
                    if (!write_q) begin
                        if (owner_q[0]) load0_d = mem_data_load_i;
                        if (owner_q[1]) load1_d = mem_data_load_i;
                    end
                end
            end
            StAck: begin
                owner_d = OWN_NONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= OWN_NONE;
            write_q      <= 1'b0;
            lat_cnt_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_ren_q    <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            load0_q      <= '0;
            load1_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_ren_q    <= mem_ren_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            load0_q      <= load0_d;
            load1_q      <= load1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    assign mem_enable_o      = mem_en_q;
    assign mem_read_enable_o = mem_ren_q;
    assign mem_addr_o        = addr_q;
    assign mem_byte_select_o = be_q;
    assign mem_data_save_o   = wdata_q;
    assign m0_data_load_o    = load0_q;
    assign m1_data_load_o    = load1_q;
    assign m0_ack_o          = ack0_q;
    assign m1_ack_o          = ack1_q;
    assign owner_o           = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-timing model checked every cycle plus directed literal checks.
module tb_sram_arbiter;

    localparam int RL1 = 1;

    logic        clk;
    logic        rst_n;
    logic        rst3_n;
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] load  [2];
    logic        ack   [2];
    logic        mem_en, mem_ren, mem_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata_fixed;
    logic [3:0]  mem_be;
    logic [1:0]  owner;
    logic        fixed_rd;

    logic        r3_req;
    logic [31:0] r3_addr;
    logic [31:0] r3_m0_load, r3_m1_load, r3_maddr, r3_mwdata;
    logic        r3_m0_ack, r3_m1_ack, r3_en, r3_ren;
    logic [3:0]  r3_mbe;
    logic [1:0]  r3_owner;

    int n_cmp = 0;
    int n_fail = 0;

    sram_arbiter #(.READ_LAT(RL1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .m0_req_i          (req[0]),
        .m0_write_i        (wr[0]),
        .m0_addr_i         (addr[0]),
        .m0_byte_select_i  (be[0]),
        .m0_data_save_i    (wdata[0]),
        .m0_data_load_o    (load[0]),
        .m0_ack_o          (ack[0]),
        .m1_req_i          (req[1]),
        .m1_write_i        (wr[1]),
        .m1_addr_i         (addr[1]),
        .m1_byte_select_i  (be[1]),
        .m1_data_save_i    (wdata[1]),
        .m1_data_load_o    (load[1]),
        .m1_ack_o          (ack[1]),
        .mem_enable_o      (mem_en),
        .mem_read_enable_o (mem_ren),
        .mem_addr_o        (mem_addr),
        .mem_byte_select_o (mem_be),
        .mem_data_save_o   (mem_wdata),
        .mem_data_load_i   (mem_rdata),
        .mem_busy_i        (mem_busy),
        .owner_o           (owner)
    );

    sram_arbiter #(.READ_LAT(3)) dut3 (
        .clk               (clk),
        .rst_n             (rst3_n),
        .m0_req_i          (r3_req),
        .m0_write_i        (1'b0),
        .m0_addr_i         (r3_addr),
        .m0_byte_select_i  (4'hF),
        .m0_data_save_i    (32'h0),
        .m0_data_load_o    (r3_m0_load),
        .m0_ack_o          (r3_m0_ack),
        .m1_req_i          (1'b0),
        .m1_write_i        (1'b0),
        .m1_addr_i         (32'h0),
        .m1_byte_select_i  (4'h0),
        .m1_data_save_i    (32'h0),
        .m1_data_load_o    (r3_m1_load),
        .m1_ack_o          (r3_m1_ack),
        .mem_enable_o      (r3_en),
        .mem_read_enable_o (r3_ren),
        .mem_addr_o        (r3_maddr),
        .mem_byte_select_o (r3_mbe),
        .mem_data_save_o   (r3_mwdata),
        .mem_data_load_i   (rdata_fixed),
        .mem_busy_i        (1'b0),
        .owner_o           (r3_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mem_rdata = fixed_rd ? rdata_fixed : {mem_addr[15:0], 16'hC0DE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: a grant at cycle t0 owns the bus for t0+1..t_end, ack at t_end+1.
    int          cyc = 0;
    bit          m_active;
    int          m_master, m_last, m_t0, m_end;
    bit          m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_load [2];
    bit          in_access, in_ack;
    int          ack_log [$];
    int          req_rise_cyc [2];
    int          ack_cyc [2];
    int          en_rise_cyc;
    logic        prev_req [2];
    logic        prev_en;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_last = 1; m_end = -1; m_t0 = 0;
            m_load[0] = '0; m_load[1] = '0;
            prev_req[0] = 0; prev_req[1] = 0; prev_en = 0;
        end else begin
            cyc++;
            in_access = m_active && cyc > m_t0 && (m_end < 0 || cyc <= m_end);
            in_ack    = m_active && m_end >= 0 && cyc == m_end + 1;
            check("mem_enable", 32'(mem_en), 32'(in_access));
            check("mem_read_enable", 32'(mem_ren), 32'(in_access && !m_write));
            if (in_access) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_byte_select", 32'(mem_be), 32'(m_be));
                if (m_write) check("mem_data_save", mem_wdata, m_wdata);
            end
            check("m0_ack", 32'(ack[0]), 32'(in_ack && m_master == 0));
            check("m1_ack", 32'(ack[1]), 32'(in_ack && m_master == 1));
            check("owner", 32'(owner),
                  (in_access || in_ack) ? ((m_master == 0) ? 32'd1 : 32'd2) : 32'd0);
            check("m0_data_load", load[0], m_load[0]);
            check("m1_data_load", load[1], m_load[1]);

            for (int m = 0; m < 2; m++) begin
                if (ack[m]) begin
                    ack_log.push_back(m);
                    ack_cyc[m] = cyc;
                end
                if (req[m] && !prev_req[m]) req_rise_cyc[m] = cyc;
                prev_req[m] = req[m];
            end
            if (mem_en && !prev_en) en_rise_cyc = cyc;
            prev_en = mem_en;

            if (!m_active) begin
                if (req[0] || req[1]) begin
                    if (req[0] && req[1]) m_master = 1 - m_last;
                    else m_master = req[0] ? 0 : 1;
                    m_last   = m_master;
                    m_active = 1;
                    m_t0     = cyc;
                    m_write  = wr[m_master];
                    m_addr   = addr[m_master];
                    m_wdata  = wdata[m_master];
                    m_be     = be[m_master];
                    m_end    = m_write ? -1 : cyc + RL1;
                end
            end else if (in_ack) begin
                m_active = 0;
            end else if (in_access) begin
                if (m_write && m_end < 0 && cyc >= m_t0 + 2 && !mem_busy) m_end = cyc;
                if (!m_write && cyc == m_end) m_load[m_master] = mem_rdata;
            end
        end
    end

    task automatic wait_ack(input int m, input int max_cyc);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ack[m] && w < max_cyc);
        if (!ack[m]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout_m%0d: ack=0 after %0d cycles, expected 1", m, max_cyc);
        end
    endtask

    // Holds req high across `count` back-to-back transactions, dropping it after the last ack.
    task automatic run_master(input int m, input bit w, input int count,
                              input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req[m] = 1; wr[m] = w; addr[m] = a; wdata[m] = d; be[m] = 4'hF;
        for (int i = 0; i < count; i++) begin
            wait_ack(m, 200);
            @(posedge clk); #1;
            addr[m]  = a + 32'(4 * (i + 1));
            wdata[m] = d + 32'(i + 1);
            if (i == count - 1) req[m] = 0;
        end
    endtask

    int base, w3, en_cnt, idx, cnt0;

    initial begin
        rst_n = 0; rst3_n = 0; mem_busy = 0; fixed_rd = 1; rdata_fixed = '0;
        r3_req = 0; r3_addr = '0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 0; wr[m] = 0; addr[m] = '0; wdata[m] = '0; be[m] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_mem_enable", 32'(mem_en), 32'd0);
        check("rst_mem_read_enable", 32'(mem_ren), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data_save", mem_wdata, 32'd0);
        check("rst_mem_byte_select", 32'(mem_be), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_acks", {30'd0, ack[1], ack[0]}, 32'd0);
        check("rst_m0_load", load[0], 32'd0);
        check("rst_m1_load", load[1], 32'd0);
        @(posedge clk); #1;
        rst_n = 1; rst3_n = 1;

        // m0 read, READ_LAT=1
        rdata_fixed = 32'h1234_5678;
        run_master(0, 0, 1, 32'h0000_0010, 32'h0);
        check("t1_ack_latency", 32'(ack_cyc[0] - req_rise_cyc[0]), 32'd2);
        check("t1_m0_load", load[0], 32'h1234_5678);
        check("t1_m1_load", load[1], 32'h0);

        // m1 write with busy held over the first three ACCESS cycles
        mem_busy = 1;
        fork
            run_master(1, 1, 1, 32'h20, 32'hDEAD_BEEF);
            begin
                w3 = 0;
                do begin @(negedge clk); w3++; end while (!mem_en && w3 < 50);
                check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
                check("t2_read_enable", 32'(mem_ren), 32'd0);
                check("t2_addr", mem_addr, 32'h20);
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                mem_busy = 0;
            end
        join
        check("t2_ack_after_busy", 32'(ack_cyc[1] - en_rise_cyc), 32'd4);
        check("t2_m1_load_kept", load[1], 32'h0);

        // Both masters requesting continuously: strict alternation starting with m0
        fixed_rd = 0;
        base = ack_log.size();
        fork
            run_master(0, 0, 4, 32'h100, 32'h0);
            run_master(1, 0, 4, 32'h200, 32'h0);
        join
        check("t3_ack_count", 32'(ack_log.size() - base), 32'd8);
        for (int i = 0; i < 8 && base + i < ack_log.size(); i++)
            check("t3_grant_order", 32'(ack_log[base + i]), 32'(i % 2));
        check("t3_m0_last_load", load[0], 32'h010C_C0DE);
        check("t3_m1_last_load", load[1], 32'h020C_C0DE);

        // m0 streams 10 requests, m1 arrives one cycle later and must win the second arbitration
        base = ack_log.size();
        fork
            run_master(0, 0, 10, 32'h300, 32'h0);
            begin
                @(posedge clk);
                run_master(1, 0, 1, 32'h400, 32'h0);
            end
        join
        idx = -1;
        for (int i = base; i < ack_log.size(); i++)
            if (idx < 0 && ack_log[i] == 1) idx = i - base;
        check("t4_m1_grant_slot", 32'(idx), 32'd1);
        check("t4_ack_count", 32'(ack_log.size() - base), 32'd11);

        // Req held one cycle past the ack starts a second transaction
        base = ack_log.size();
        @(posedge clk); #1;
        req[0] = 1; wr[0] = 0; addr[0] = 32'h500; be[0] = 4'h3;
        wait_ack(0, 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[0] = 0;
        wait_ack(0, 20);
        repeat (3) @(negedge clk);
        cnt0 = 0;
        for (int i = base; i < ack_log.size(); i++) if (ack_log[i] == 0) cnt0++;
        check("t6_two_txns", 32'(cnt0), 32'd2);

        // READ_LAT=3 instance: reset in the second ACCESS cycle, then re-issue
        rdata_fixed = 32'hCAFE_F00D;
        @(posedge clk); #1;
        r3_req = 1; r3_addr = 32'h40;
        w3 = 0;
        do begin @(negedge clk); w3++; end while (!r3_en && w3 < 20);
        check("t5_en_start", 32'(w3), 32'd2);
        @(posedge clk); #1;
        rst3_n = 0; r3_req = 0;
        #1;
        check("t5_en_drop", 32'(r3_en), 32'd0);
        check("t5_ren_drop", 32'(r3_ren), 32'd0);
        check("t5_owner_clear", 32'(r3_owner), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_ack", 32'(r3_m0_ack), 32'd0);
        end
        @(posedge clk); #1;
        rst3_n = 1;
        @(posedge clk); #1;
        r3_req = 1;
        w3 = 0; en_cnt = 0;
        do begin
            @(negedge clk);
            w3++;
            if (r3_en) en_cnt++;
        end while (!r3_m0_ack && w3 < 20);
        check("t5_reissue_latency", 32'(w3), 32'd5);
        check("t5_enable_cycles", 32'(en_cnt), 32'd3);
        check("t5_load", r3_m0_load, 32'hCAFE_F00D);
        @(posedge clk); #1;
        r3_req = 0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

endmodule
